// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, Bomberman keymap codes, key indices and parser state type.
package ps2_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CODE_W     = 9;
  localparam int unsigned KEY_IDX_W  = 4;
  localparam int unsigned SKIP_W     = 3;
  localparam int unsigned PAUSE_SKIP = 7;

  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_PAUSE = 8'hE1;

  localparam logic [BYTE_W-1:0] RSP_BAT_OK = 8'hAA;
  localparam logic [BYTE_W-1:0] RSP_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] RSP_RESEND = 8'hFE;
  localparam logic [BYTE_W-1:0] RSP_ECHO   = 8'hEE;
  localparam logic [BYTE_W-1:0] RSP_ERR_LO = 8'h00;
  localparam logic [BYTE_W-1:0] RSP_ERR_HI = 8'hFF;

  localparam logic [BYTE_W-1:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [BYTE_W-1:0] FAKE_SHIFT_R = 8'h59;

  localparam logic [CODE_W-1:0] KC_P1_UP      = 9'h01D;
  localparam logic [CODE_W-1:0] KC_P1_DOWN    = 9'h01B;
  localparam logic [CODE_W-1:0] KC_P1_LEFT    = 9'h01C;
  localparam logic [CODE_W-1:0] KC_P1_RIGHT   = 9'h023;
  localparam logic [CODE_W-1:0] KC_P1_BOMB    = 9'h029;
  localparam logic [CODE_W-1:0] KC_P2_UP      = 9'h175;
  localparam logic [CODE_W-1:0] KC_P2_DOWN    = 9'h172;
  localparam logic [CODE_W-1:0] KC_P2_LEFT    = 9'h16B;
  localparam logic [CODE_W-1:0] KC_P2_RIGHT   = 9'h174;
  localparam logic [CODE_W-1:0] KC_P2_BOMB    = 9'h05A;
  localparam logic [CODE_W-1:0] KC_P2_BOMB_KP = 9'h15A;

  localparam logic [KEY_IDX_W-1:0] KEY_P1_UP    = 4'd0;
  localparam logic [KEY_IDX_W-1:0] KEY_P1_DOWN  = 4'd1;
  localparam logic [KEY_IDX_W-1:0] KEY_P1_LEFT  = 4'd2;
  localparam logic [KEY_IDX_W-1:0] KEY_P1_RIGHT = 4'd3;
  localparam logic [KEY_IDX_W-1:0] KEY_P1_BOMB  = 4'd4;
  localparam logic [KEY_IDX_W-1:0] KEY_P2_UP    = 4'd5;
  localparam logic [KEY_IDX_W-1:0] KEY_P2_DOWN  = 4'd6;
  localparam logic [KEY_IDX_W-1:0] KEY_P2_LEFT  = 4'd7;
  localparam logic [KEY_IDX_W-1:0] KEY_P2_RIGHT = 4'd8;
  localparam logic [KEY_IDX_W-1:0] KEY_P2_BOMB  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  function automatic logic is_dev_rsp(input logic [BYTE_W-1:0] b);
    return (b == RSP_BAT_OK) || (b == RSP_ACK) || (b == RSP_RESEND) ||
           (b == RSP_ECHO) || (b == RSP_ERR_LO) || (b == RSP_ERR_HI);
  endfunction

  function automatic logic is_fake_shift(input logic [BYTE_W-1:0] b);
    return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational {ext,code} -> player key index lookup; shared with the menu controller.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [CODE_W-1:0]    i_code,
  output logic                 o_hit_c,
  output logic [KEY_IDX_W-1:0] o_key_idx_c
);

  always_comb begin
    o_hit_c     = 1'b1;
    o_key_idx_c = '0;
    case (i_code)
      KC_P1_UP:      o_key_idx_c = KEY_P1_UP;
      KC_P1_DOWN:    o_key_idx_c = KEY_P1_DOWN;
      KC_P1_LEFT:    o_key_idx_c = KEY_P1_LEFT;
      KC_P1_RIGHT:   o_key_idx_c = KEY_P1_RIGHT;
      KC_P1_BOMB:    o_key_idx_c = KEY_P1_BOMB;
      KC_P2_UP:      o_key_idx_c = KEY_P2_UP;
      KC_P2_DOWN:    o_key_idx_c = KEY_P2_DOWN;
      KC_P2_LEFT:    o_key_idx_c = KEY_P2_LEFT;
      KC_P2_RIGHT:   o_key_idx_c = KEY_P2_RIGHT;
      KC_P2_BOMB,
      KC_P2_BOMB_KP: o_key_idx_c = KEY_P2_BOMB;
      default:       o_hit_c     = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code parser: turns receiver bytes into key events and a held-key bitmap
// for the two Bomberman players.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned NB_KEYS        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  input  logic               flush,
  output logic [NB_KEYS-1:0] key_state,
  output logic               event_valid,
  output logic [CODE_W-1:0]  event_code,
  output logic               event_release,
  output logic               event_mapped,
  output logic               proto_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_state_e          r_state;
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [NB_KEYS-1:0]  r_key_state;
  logic                r_event_valid;
  logic [CODE_W-1:0]   r_event_code;
  logic                r_event_release;
  logic                r_event_mapped;
  logic                r_proto_error;

  logic                w_prefix_err;
  ps2_state_e          w_eff_state;
  logic                w_emit;
  logic                w_release;
  logic [CODE_W-1:0]   w_code;
  logic                w_hit;
  logic [KEY_IDX_W-1:0] w_key_idx;

  // A prefix where a code byte belongs flags an error and restarts parsing from IDLE.
  always_comb begin
    w_prefix_err = 1'b0;
    case (r_state)
      ST_EXT:             w_prefix_err = (byte_in == PS2_EXT);
      ST_BRK, ST_EXT_BRK: w_prefix_err = (byte_in == PS2_EXT) || (byte_in == PS2_BRK);
      default:            w_prefix_err = 1'b0;
    endcase
    w_eff_state = w_prefix_err ? ST_IDLE : r_state;
  end

  always_comb begin
    w_emit    = 1'b0;
    w_release = 1'b0;
    case (w_eff_state)
      ST_IDLE:    w_emit = (byte_in != PS2_EXT) && (byte_in != PS2_BRK) &&
                           (byte_in != PS2_PAUSE) && !is_dev_rsp(byte_in);
      ST_EXT:     w_emit = (byte_in != PS2_BRK) && !is_fake_shift(byte_in);
      ST_BRK: begin
        w_emit    = 1'b1;
        w_release = 1'b1;
      end
      ST_EXT_BRK: begin
        w_emit    = !is_fake_shift(byte_in);
        w_release = 1'b1;
      end
      default:    w_emit = 1'b0;
    endcase
    w_code = {(w_eff_state == ST_EXT) || (w_eff_state == ST_EXT_BRK), byte_in};
  end

  ps2_keymap u_keymap (
    .i_code      (w_code),
    .o_hit_c     (w_hit),
    .o_key_idx_c (w_key_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_tmo_cnt       <= '0;
      r_skip_cnt      <= '0;
      r_key_state     <= '0;
      r_event_valid   <= 1'b0;
      r_event_code    <= '0;
      r_event_release <= 1'b0;
      r_event_mapped  <= 1'b0;
      r_proto_error   <= 1'b0;
    end else begin
      r_event_valid <= 1'b0;
      if (flush) begin
        r_state       <= ST_IDLE;
        r_tmo_cnt     <= '0;
        r_skip_cnt    <= '0;
        r_key_state   <= '0;
        r_proto_error <= 1'b0;
      end else if (byte_valid) begin
        r_tmo_cnt <= '0;
        r_state   <= ST_IDLE;
        if (w_prefix_err) r_proto_error <= 1'b1;
        case (w_eff_state)
          ST_IDLE: begin
            if (byte_in == PS2_EXT) begin
              r_state <= ST_EXT;
            end else if (byte_in == PS2_BRK) begin
              r_state <= ST_BRK;
            end else if (byte_in == PS2_PAUSE) begin
              r_state    <= ST_SKIP;
              r_skip_cnt <= SKIP_W'(PAUSE_SKIP);
            end
          end
          ST_EXT:  if (byte_in == PS2_BRK) r_state <= ST_EXT_BRK;
          ST_SKIP: begin
            r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
            if (r_skip_cnt > SKIP_W'(1)) r_state <= ST_SKIP;
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_emit) begin
          r_event_valid   <= 1'b1;
          r_event_code    <= w_code;
          r_event_release <= w_release;
          r_event_mapped  <= w_hit;
          if (w_hit) r_key_state[w_key_idx] <= !w_release;
        end
      end else if (r_state != ST_IDLE) begin
        // Abandon a stalled sequence so a lost byte cannot wedge the parser.
        if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          r_state       <= ST_IDLE;
          r_tmo_cnt     <= '0;
          r_proto_error <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign key_state     = r_key_state;
  assign event_valid   = r_event_valid;
  assign event_code    = r_event_code;
  assign event_release = r_event_release;
  assign event_mapped  = r_event_mapped;
  assign proto_error   = r_proto_error;

endmodule
